// File: rtl/lsu_llsc_pkg.sv
// Shared encodings for the openmips load/store unit: op codes, exception codes,
// FSM state encoding and big-endian byte-lane select constants.
package mips_lsu_pkg;

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_SB  = 4'd5;
    localparam logic [3:0] OP_SH  = 4'd6;
    localparam logic [3:0] OP_SW  = 4'd7;
    localparam logic [3:0] OP_LL  = 4'd8;
    localparam logic [3:0] OP_SC  = 4'd9;

    localparam logic [1:0] EXC_NONE = 2'd0;
    localparam logic [1:0] EXC_ADEL = 2'd1;
    localparam logic [1:0] EXC_ADES = 2'd2;
    localparam logic [1:0] EXC_BUS  = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Big-endian lanes: byte offset 0 lives in bits 31:24.
    localparam logic [3:0] SEL_B0 = 4'b1000;
    localparam logic [3:0] SEL_B1 = 4'b0100;
    localparam logic [3:0] SEL_B2 = 4'b0010;
    localparam logic [3:0] SEL_B3 = 4'b0001;
    localparam logic [3:0] SEL_H0 = 4'b1100;
    localparam logic [3:0] SEL_H1 = 4'b0011;
    localparam logic [3:0] SEL_W  = 4'b1111;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    function automatic size_e op_size(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_B;
            OP_LH, OP_LHU, OP_SH: return SZ_H;
            default:              return SZ_W;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_SC);
    endfunction

    function automatic logic op_is_signed(input logic [3:0] op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

endpackage

// File: rtl/lsu_llsc_if.sv
// Pipeline-side and data-RAM-side signals of the load/store unit.
interface lsu_llsc_if;
    logic        in_valid;
    logic [3:0]  in_op;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        flush;
    logic        stall_req;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_exc;
    logic        llbit;

    modport slave (
        input  in_valid, in_op, in_addr, in_wdata, flush, mem_rdata, mem_ack,
        output stall_req, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
        output out_valid, out_data, out_exc, llbit
    );

    modport master (
        output in_valid, in_op, in_addr, in_wdata, flush, mem_rdata, mem_ack,
        input  stall_req, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
        input  out_valid, out_data, out_exc, llbit
    );
endinterface

// File: rtl/lsu_llsc_align.sv
// Byte-lane steering: lane selects, store replication, load extract/extend
// and the misalignment flag for a given op and low address bits.
module lsu_align
    import mips_lsu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [3:0]  sel_b;
    logic        sext;

    always_comb begin
        lane_b = rdata_i[31:24];
        sel_b  = SEL_B0;
        case (addr_lo_i)
            2'd1:    begin lane_b = rdata_i[23:16]; sel_b = SEL_B1; end
            2'd2:    begin lane_b = rdata_i[15:8];  sel_b = SEL_B2; end
            2'd3:    begin lane_b = rdata_i[7:0];   sel_b = SEL_B3; end
            default: begin lane_b = rdata_i[31:24]; sel_b = SEL_B0; end
        endcase
        lane_h = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];
        sext   = op_is_signed(op_i);

        sel_o        = SEL_W;
        wdata_o      = wdata_i;
        rdata_o      = rdata_i;
        misaligned_o = 1'b0;
        case (op_size(op_i))
            SZ_B: begin
                sel_o   = sel_b;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{sext & lane_b[7]}}, lane_b};
            end
            SZ_H: begin
                sel_o        = addr_lo_i[1] ? SEL_H1 : SEL_H0;
                wdata_o      = {2{wdata_i[15:0]}};
                rdata_o      = {{16{sext & lane_h[15]}}, lane_h};
                misaligned_o = addr_lo_i[0];
            end
            default: misaligned_o = |addr_lo_i;
        endcase
    end
endmodule

// File: rtl/lsu_llsc.sv
// Memory-stage load/store unit with LL/SC link bit, request/ack handshake
// toward data RAM, bus-error timeout and pipeline stall request.
module lsu_llsc
    import mips_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset_n,
    lsu_llsc_if.slave bus
);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        flushed_q, flushed_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_sel_q, mem_sel_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic [1:0]  out_exc_q, out_exc_d;
    logic        llbit_q, llbit_d;

    logic        idle;
    logic [3:0]  align_op;
    logic [1:0]  align_lo;
    logic [3:0]  align_sel;
    logic [31:0] align_wdata;
    logic [31:0] align_rdata;
    logic        align_mis;

    assign idle = (state_q == ST_IDLE);

    // In IDLE the aligner looks at the incoming op; afterwards at the latched one.
    assign align_op = idle ? bus.in_op : op_q;
    assign align_lo = idle ? bus.in_addr[1:0] : addr_lo_q;

    lsu_align u_align (
        .op_i        (align_op),
        .addr_lo_i   (align_lo),
        .wdata_i     (bus.in_wdata),
        .rdata_i     (bus.mem_rdata),
        .sel_o       (align_sel),
        .wdata_o     (align_wdata),
        .rdata_o     (align_rdata),
        .misaligned_o(align_mis)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_lo_d   = addr_lo_q;
        tmo_d       = tmo_q;
        flushed_d   = flushed_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_sel_d   = mem_sel_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_exc_d   = out_exc_q;
        llbit_d     = llbit_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && !bus.flush) begin
                    op_d      = bus.in_op;
                    addr_lo_d = bus.in_addr[1:0];
                    if (align_mis) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        out_data_d  = '0;
                        out_exc_d   = op_is_store(bus.in_op) ? EXC_ADES : EXC_ADEL;
                        if (bus.in_op == OP_SC) llbit_d = 1'b0;
                    end else if (bus.in_op == OP_SC && !llbit_q) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        out_data_d  = '0;
                        out_exc_d   = EXC_NONE;
                        llbit_d     = 1'b0;
                    end else begin
                        state_d     = ST_REQ;
                        tmo_d       = '0;
                        flushed_d   = 1'b0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = op_is_store(bus.in_op);
                        mem_sel_d   = align_sel;
                        mem_addr_d  = {bus.in_addr[31:2], 2'b00};
                        mem_wdata_d = align_wdata;
                    end
                end
            end
            ST_REQ: begin
                if (bus.flush) flushed_d = 1'b1;
                if (bus.mem_ack || tmo_q == TMO_LAST) begin
                    state_d     = ST_DONE;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    out_valid_d = !(flushed_q || bus.flush);
                    if (bus.mem_ack) begin
                        out_exc_d = EXC_NONE;
                        if (op_q == OP_SC)          out_data_d = 32'd1;
                        else if (op_is_store(op_q)) out_data_d = '0;
                        else                        out_data_d = align_rdata;
                        if (op_q == OP_LL && !flushed_q) llbit_d = 1'b1;
                    end else begin
                        out_exc_d  = EXC_BUS;
                        out_data_d = '0;
                    end
                    if (op_q == OP_SC) llbit_d = 1'b0;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A flush always beats a link set landing on the same edge.
        if (bus.flush) llbit_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            addr_lo_q   <= '0;
            tmo_q       <= '0;
            flushed_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_sel_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_exc_q   <= EXC_NONE;
            llbit_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_lo_q   <= addr_lo_d;
            tmo_q       <= tmo_d;
            flushed_q   <= flushed_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_sel_q   <= mem_sel_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_exc_q   <= out_exc_d;
            llbit_q     <= llbit_d;
        end
    end

    assign bus.stall_req = (idle && bus.in_valid) || (state_q == ST_REQ);
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_sel   = mem_sel_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_exc   = out_exc_q;
    assign bus.llbit     = llbit_q;
endmodule

// File: tb/tb_lsu_llsc.sv
// Directed bench for lsu_llsc: each op runs a fixed 10-cycle window while a
// scripted RAM acks on a chosen REQ cycle; results are compared inline.
module tb_lsu_llsc;
    import mips_lsu_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    int          r_lat, r_pulses, r_req, r_stall;
    logic [31:0] r_data, r_addr, r_wdata;
    logic [1:0]  r_exc;
    logic [3:0]  r_sel;
    logic        r_we;

    lsu_llsc_if intf();

    lsu_llsc #(.TIMEOUT_CYCLES(4)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (intf.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // ack_at: 1-based REQ cycle raising mem_ack (0 = never); flush_at: window cycle of flush (-1 = none)
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int ack_at, input int flush_at);
        r_lat = 0; r_pulses = 0; r_req = 0; r_stall = 0;
        r_data = '0; r_exc = '0; r_sel = '0; r_we = 1'b0; r_addr = '0; r_wdata = '0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            intf.in_valid = (c == 0);
            intf.in_op    = op;
            intf.in_addr  = addr;
            intf.in_wdata = wdata;
            intf.flush    = (c == flush_at);
            #1;
            intf.mem_ack   = 1'b0;
            intf.mem_rdata = 32'hDEAD_BEEF;
            if (intf.mem_req) begin
                r_req++;
                r_we = intf.mem_we; r_sel = intf.mem_sel;
                r_addr = intf.mem_addr; r_wdata = intf.mem_wdata;
                if (r_req == ack_at) begin
                    intf.mem_ack   = 1'b1;
                    intf.mem_rdata = rdata;
                end
            end
            if (intf.stall_req) r_stall++;
            if (intf.out_valid) begin
                r_pulses++;
                if (r_lat == 0) begin
                    r_lat = c + 1; r_data = intf.out_data; r_exc = intf.out_exc;
                end
            end
        end
        $display("op=%0d addr=%h lat=%0d pulses=%0d data=%h exc=%0d req=%0d we=%0d sel=%b wdata=%h stall=%0d llbit=%0d",
                 op, addr, r_lat, r_pulses, r_data, r_exc, r_req, r_we, r_sel, r_wdata, r_stall, intf.llbit);
    endtask

    task automatic test_reset();
        intf.in_valid = 0; intf.in_op = 0; intf.in_addr = 0; intf.in_wdata = 0;
        intf.flush = 0; intf.mem_rdata = 0; intf.mem_ack = 0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (intf.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", intf.mem_req); end
        checks++; if (intf.stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", intf.stall_req); end
        checks++; if (intf.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", intf.out_valid); end
        checks++; if (intf.llbit !== 1'b0) begin errors++; $display("FAIL reset_llbit got %b exp 0", intf.llbit); end
        checks++;
        if ({intf.mem_we, intf.mem_sel, intf.mem_addr, intf.mem_wdata, intf.out_data, intf.out_exc} !== '0) begin
            errors++; $display("FAIL reset_regs got we=%b sel=%b addr=%h wd=%h data=%h exc=%0d exp all 0",
                               intf.mem_we, intf.mem_sel, intf.mem_addr, intf.mem_wdata, intf.out_data, intf.out_exc);
        end
        $display("reset released");
    endtask

    task automatic test_lw_wait();
        run_op(OP_LW, 32'h100, 32'h0, 32'h1122_3344, 3, -1);
        checks++; if (r_lat !== 5) begin errors++; $display("FAIL lw_latency got %0d exp 5", r_lat); end
        checks++; if (r_data !== 32'h1122_3344) begin errors++; $display("FAIL lw_data got %h exp 11223344", r_data); end
        checks++; if (r_stall !== 4) begin errors++; $display("FAIL lw_stall got %0d exp 4", r_stall); end
        checks++; if ({r_we, r_sel, r_addr} !== {1'b0, 4'b1111, 32'h100}) begin
            errors++; $display("FAIL lw_bus got we=%b sel=%b addr=%h exp 0 1111 00000100", r_we, r_sel, r_addr); end
        checks++; if (r_pulses !== 1) begin errors++; $display("FAIL lw_pulses got %0d exp 1", r_pulses); end
    endtask

    task automatic test_subword();
        run_op(OP_LB, 32'h103, 32'h0, 32'h1122_33F4, 1, -1);
        checks++; if (r_data !== 32'hFFFF_FFF4) begin errors++; $display("FAIL lb_data got %h exp fffffff4", r_data); end
        checks++; if (r_sel !== 4'b0001) begin errors++; $display("FAIL lb_sel got %b exp 0001", r_sel); end
        checks++; if (r_lat !== 3) begin errors++; $display("FAIL lb_latency got %0d exp 3", r_lat); end
        run_op(OP_LBU, 32'h103, 32'h0, 32'h1122_33F4, 1, -1);
        checks++; if (r_data !== 32'h0000_00F4) begin errors++; $display("FAIL lbu_data got %h exp 000000f4", r_data); end
        run_op(OP_SB, 32'h101, 32'h0000_00AB, 32'h0, 1, -1);
        checks++; if ({r_we, r_sel, r_addr, r_wdata} !== {1'b1, 4'b0100, 32'h100, 32'hABAB_ABAB}) begin
            errors++; $display("FAIL sb_bus got we=%b sel=%b addr=%h wd=%h exp 1 0100 00000100 abababab", r_we, r_sel, r_addr, r_wdata); end
        run_op(OP_LH, 32'h102, 32'h0, 32'h1234_8001, 1, -1);
        checks++; if (r_data !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_data got %h exp ffff8001", r_data); end
        run_op(OP_LHU, 32'h100, 32'h0, 32'h8001_1234, 1, -1);
        checks++; if (r_data !== 32'h0000_8001) begin errors++; $display("FAIL lhu_data got %h exp 00008001", r_data); end
        run_op(OP_SH, 32'h102, 32'h1234_BEEF, 32'h0, 1, -1);
        checks++; if ({r_sel, r_wdata} !== {4'b0011, 32'hBEEF_BEEF}) begin
            errors++; $display("FAIL sh_bus got sel=%b wd=%h exp 0011 beefbeef", r_sel, r_wdata); end
    endtask

    task automatic test_llsc();
        run_op(OP_LL, 32'h200, 32'h0, 32'hCAFE_0001, 1, -1);
        checks++; if (r_data !== 32'hCAFE_0001) begin errors++; $display("FAIL ll_data got %h exp cafe0001", r_data); end
        checks++; if (intf.llbit !== 1'b1) begin errors++; $display("FAIL ll_llbit got %b exp 1", intf.llbit); end
        run_op(OP_SC, 32'h200, 32'd5, 32'h0, 1, -1);
        checks++; if ({r_req, r_we, r_wdata} !== {32'd1, 1'b1, 32'd5}) begin
            errors++; $display("FAIL sc_write got req=%0d we=%b wd=%h exp 1 1 00000005", r_req, r_we, r_wdata); end
        checks++; if (r_data !== 32'd1) begin errors++; $display("FAIL sc_status got %h exp 1", r_data); end
        checks++; if (intf.llbit !== 1'b0) begin errors++; $display("FAIL sc_llbit got %b exp 0", intf.llbit); end
        run_op(OP_SC, 32'h200, 32'd6, 32'h0, 1, -1);
        checks++; if ({r_req, r_lat, r_data} !== {32'd0, 32'd2, 32'd0}) begin
            errors++; $display("FAIL sc2_fail got req=%0d lat=%0d data=%h exp 0 2 0", r_req, r_lat, r_data); end
    endtask

    task automatic test_flush_llsc();
        run_op(OP_LL, 32'h200, 32'h0, 32'h1, 1, -1);
        run_op(OP_LW, 32'h0, 32'h0, 32'h0, 0, 0);
        checks++; if ({r_req, r_pulses} !== {32'd0, 32'd0}) begin
            errors++; $display("FAIL idle_flush_accept got req=%0d pulses=%0d exp 0 0", r_req, r_pulses); end
        checks++; if (intf.llbit !== 1'b0) begin errors++; $display("FAIL flush_llbit got %b exp 0", intf.llbit); end
        run_op(OP_SC, 32'h200, 32'd7, 32'h0, 1, -1);
        checks++; if ({r_req, r_data} !== {32'd0, 32'd0}) begin
            errors++; $display("FAIL sc_after_flush got req=%0d data=%h exp 0 0", r_req, r_data); end
        run_op(OP_LL, 32'h200, 32'h0, 32'h1, 1, 1);
        checks++; if ({intf.llbit, r_pulses} !== {1'b0, 32'd0}) begin
            errors++; $display("FAIL ll_flush_same got llbit=%b pulses=%0d exp 0 0", intf.llbit, r_pulses); end
    endtask

    task automatic test_misaligned();
        run_op(OP_LH, 32'h101, 32'h0, 32'h0, 1, -1);
        checks++; if ({r_exc, r_req, r_lat} !== {EXC_ADEL, 32'd0, 32'd2}) begin
            errors++; $display("FAIL lh_misaligned got exc=%0d req=%0d lat=%0d exp 1 0 2", r_exc, r_req, r_lat); end
        run_op(OP_SW, 32'h102, 32'h0, 32'h0, 1, -1);
        checks++; if ({r_exc, r_req} !== {EXC_ADES, 32'd0}) begin
            errors++; $display("FAIL sw_misaligned got exc=%0d req=%0d exp 2 0", r_exc, r_req); end
        run_op(OP_LL, 32'h201, 32'h0, 32'h0, 1, -1);
        checks++; if ({r_exc, intf.llbit} !== {EXC_ADEL, 1'b0}) begin
            errors++; $display("FAIL ll_misaligned got exc=%0d llbit=%b exp 1 0", r_exc, intf.llbit); end
    endtask

    task automatic test_timeout();
        run_op(OP_LW, 32'h300, 32'h0, 32'h0, 0, -1);
        checks++; if (r_req !== 4) begin errors++; $display("FAIL timeout_req_cycles got %0d exp 4", r_req); end
        checks++; if ({r_exc, r_lat} !== {EXC_BUS, 32'd6}) begin
            errors++; $display("FAIL timeout_exc got exc=%0d lat=%0d exp 3 6", r_exc, r_lat); end
    endtask

    task automatic test_back_to_back();
        run_op(OP_SW, 32'h400, 32'h77, 32'h0, 3, 1);
        checks++; if ({r_req, r_we, r_wdata, r_pulses} !== {32'd3, 1'b1, 32'h77, 32'd0}) begin
            errors++; $display("FAIL flush_req_store got req=%0d we=%b wd=%h pulses=%0d exp 3 1 77 0", r_req, r_we, r_wdata, r_pulses); end
        run_op(OP_LW, 32'h404, 32'h0, 32'hA5A5_5A5A, 2, -1);
        checks++; if ({r_lat, r_data, r_exc} !== {32'd4, 32'hA5A5_5A5A, EXC_NONE}) begin
            errors++; $display("FAIL after_flush_lw got lat=%0d data=%h exc=%0d exp 4 a5a55a5a 0", r_lat, r_data, r_exc); end
    endtask

    task automatic test_reset_mid_req();
        run_op(OP_LL, 32'h200, 32'h0, 32'h1, 1, -1);
        @(posedge clk); #1;
        intf.in_valid = 1; intf.in_op = OP_LW; intf.in_addr = 32'h500;
        @(posedge clk); #1;
        intf.in_valid = 0;
        checks++; if (intf.mem_req !== 1'b1) begin errors++; $display("FAIL mid_req_active got %b exp 1", intf.mem_req); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({intf.mem_req, intf.stall_req, intf.llbit} !== 3'b000) begin
            errors++; $display("FAIL mid_req_reset got req=%b stall=%b llbit=%b exp 0 0 0", intf.mem_req, intf.stall_req, intf.llbit); end
        @(posedge clk); #1 reset_n = 1'b1;
        $display("reset during REQ done");
    endtask

    initial begin
        test_reset();
        test_lw_wait();
        test_subword();
        test_llsc();
        test_flush_llsc();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid_req();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
